odd_even_merge_sort_pipe: RTL and testbench

- Fully pipelined Batcher odd-even merge sorter for N = 2**LOG_INPUT lanes, one register stage per comparator layer.
- Successor to the fixed-direction, free-running merge network. Adds:
  - valid/ready backpressure;
  - runtime per-vector sort direction;
  - per-lane source-index tags, so downstream blocks get the permutation (argsort) as well as the sorted data.
- Sits between the input packer and the top-k/median selectors in the sorting datapath.

---
 rtl/odd_even_merge_sort_pipe.sv | 158 +++++++++++++++
 tb/tb_odd_even_merge_sort_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_even_merge_sort_pipe.sv
// rtl/odd_even_merge_sort_pipe.sv - Pipelined Batcher odd-even merge sorter with valid/ready, runtime direction and argsort tags.
// One register stage per comparator layer; the whole pipe advances together when the output slot frees.
module odd_even_merge_sort_pipe #(
    parameter int LOG_INPUT  = 3,
    parameter int DATA_WIDTH = 8,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  x_valid,
    output logic                                  x_ready,
    input  logic                                  x_dir,
    input  logic [DATA_WIDTH*(1<<LOG_INPUT)-1:0]  x,
    output logic [DATA_WIDTH*(1<<LOG_INPUT)-1:0]  y,
    output logic [LOG_INPUT*(1<<LOG_INPUT)-1:0]   y_idx,
    output logic                                  y_dir,
    output logic                                  y_valid,
    input  logic                                  y_ready
);

    localparam int N = 1 << LOG_INPUT;
    localparam int S = LOG_INPUT * (LOG_INPUT + 1) / 2;

    typedef logic [N-1:0][DATA_WIDTH-1:0] dvec_t;
    typedef logic [N-1:0][LOG_INPUT-1:0]  tvec_t;

    generate
        if (LOG_INPUT < 1 || LOG_INPUT > 6) begin : g_bad_log_input
            $error("odd_even_merge_sort_pipe: LOG_INPUT must be in 1..6");
        end
    endgenerate

    // Stage s enumerates (p,k) as p = 1,2,4..; k = p down to 1.
    function automatic int stage_k(input int s);
        int c;
        int r;
        c = 0;
        r = 1;
        for (int lp = 0; lp < 6; lp++) begin
            for (int lk = lp; lk >= 0; lk--) begin
                if (c == s) r = 1 << lk;
                c++;
            end
        end
        return r;
    endfunction

    function automatic int stage_p(input int s);
        int c;
        int r;
        c = 0;
        r = 1;
        for (int lp = 0; lp < 6; lp++) begin
            for (int lk = lp; lk >= 0; lk--) begin
                if (c == s) r = 1 << lp;
                c++;
            end
        end
        return r;
    endfunction

    function automatic bit is_pair(input int a, input int p, input int k);
        int j0;
        j0 = k % p;
        return (a >= j0) && (((a - j0) % (2 * k)) < k) && ((a + k) < N) &&
               ((a / (2 * p)) == ((a + k) / (2 * p)));
    endfunction

    function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (SIGNED) return $signed(a) > $signed(b);
        else        return a > b;
    endfunction

    dvec_t        dat_q [S];
    dvec_t        dat_d [S];
    tvec_t        tag_q [S];
    tvec_t        tag_d [S];
    logic [S-1:0] dir_q, dir_d;
    logic [S-1:0] vld_q, vld_d;

    dvec_t cd, nd;
    tvec_t ct, nt;
    logic  cdir, cv;
    int    kk, pp, ps, bi;
    logic  ce;

    assign ce      = !vld_q[S-1] || y_ready;
    assign x_ready = ce;
    assign y       = dat_q[S-1];
    assign y_idx   = tag_q[S-1];
    assign y_dir   = dir_q[S-1];
    assign y_valid = vld_q[S-1];

    always_comb begin
        dat_d = dat_q;
        tag_d = tag_q;
        dir_d = dir_q;
        vld_d = vld_q;
        cd    = '0;
        ct    = '0;
        nd    = '0;
        nt    = '0;
        cdir  = 1'b0;
        cv    = 1'b0;
        kk    = 1;
        pp    = 1;
        ps    = 0;
        bi    = 0;
        for (int s = 0; s < S; s++) begin
            ps   = (s > 0) ? s - 1 : 0;
            cd   = dat_q[ps];
            ct   = tag_q[ps];
            cdir = dir_q[ps];
            cv   = vld_q[ps];
            if (s == 0) begin
                cd   = x;
                cdir = x_dir;
                cv   = x_valid;
                for (int l = 0; l < N; l++) ct[l] = LOG_INPUT'(l);
            end
            kk = stage_k(s);
            pp = stage_p(s);
            nd = cd;
            nt = ct;
            for (int a = 0; a < N; a++) begin
                bi = ((a + kk) < N) ? a + kk : a;
                // Strict compare keeps equal values in place so ties are deterministic.
                if (is_pair(a, pp, kk) && (cdir ? gt(cd[a], cd[bi]) : gt(cd[bi], cd[a]))) begin
                    nd[a]  = cd[bi];
                    nd[bi] = cd[a];
                    nt[a]  = ct[bi];
                    nt[bi] = ct[a];
                end
            end
            dat_d[s] = nd;
            tag_d[s] = nt;
            dir_d[s] = cdir;
            vld_d[s] = cv;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < S; s++) begin
                dat_q[s] <= '0;
                tag_q[s] <= '0;
            end
            dir_q <= '0;
            vld_q <= '0;
        end else if (ce) begin
            dat_q <= dat_d;
            tag_q <= tag_d;
            dir_q <= dir_d;
            vld_q <= vld_d;
        end
    end

endmodule

// File: tb/tb_odd_even_merge_sort_pipe.sv
// tb/tb_odd_even_merge_sort_pipe.sv - Scoreboard bench for odd_even_merge_sort_pipe (unsigned and signed instances).
module tb_odd_even_merge_sort_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid;
    logic        x_dir;
    logic [63:0] x;
    logic        y_ready;

    logic        xr_u, du, vu;
    logic [63:0] yu;
    logic [23:0] iu;
    logic        xr_s, ds, vs;
    logic [63:0] ys;
    logic [23:0] is_;

    always #5 clk = ~clk;

    odd_even_merge_sort_pipe #(.LOG_INPUT(3), .DATA_WIDTH(8), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(xr_u), .x_dir(x_dir), .x(x),
        .y(yu), .y_idx(iu), .y_dir(du), .y_valid(vu), .y_ready(y_ready)
    );

    odd_even_merge_sort_pipe #(.LOG_INPUT(3), .DATA_WIDTH(8), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(xr_s), .x_dir(x_dir), .x(x),
        .y(ys), .y_idx(is_), .y_dir(ds), .y_valid(vs), .y_ready(y_ready)
    );

    typedef struct {
        logic [63:0] y;
        logic [23:0] idx;
        logic        dir;
        bit          hidx;
        logic [63:0] xin;
    } exp_t;

    exp_t qu[$];
    exp_t qs[$];

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;
    bit bp_seen  = 1'b0;
    int bp_cnt   = 0;

    bit          pstall [2];
    logic [63:0] py     [2];
    logic [23:0] pi     [2];
    logic        pd     [2];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [63:0] pk8(input int v[8]);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(v[i]);
        return r;
    endfunction

    function automatic logic [23:0] pk3(input int v[8]);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'(v[i]);
        return r;
    endfunction

    function automatic bit less(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        if (sgn) return $signed(a) < $signed(b);
        else     return a < b;
    endfunction

    function automatic logic [63:0] sort_model(input logic [63:0] xin, input bit dir, input bit sgn);
        logic [7:0]  v [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) v[i] = xin[8*i +: 8];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 7; j++) begin
                if (dir ? less(v[j+1], v[j], sgn) : less(v[j], v[j+1], sgn)) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v[i];
        return r;
    endfunction

    function automatic bit perm_ok(input logic [63:0] xin, input logic [63:0] yy, input logic [23:0] ii);
        logic [7:0] seen;
        int         id;
        bit         ok;
        seen = '0;
        ok   = 1'b1;
        for (int l = 0; l < 8; l++) begin
            id = int'(ii[3*l +: 3]);
            if (seen[id]) ok = 1'b0;
            seen[id] = 1'b1;
            if (xin[8*id +: 8] !== yy[8*l +: 8]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic mon_one(input logic [63:0] yy, input logic [23:0] ii, input logic dd, input logic vv, input int sg);
        exp_t e;
        bit   have;
        if (pstall[sg])
            check(vv && yy === py[sg] && ii === pi[sg] && dd === pd[sg], "stall_hold", yy, py[sg]);
        if (vv && y_ready) begin
            have = 1'b0;
            if (sg == 1 && qs.size() > 0) begin e = qs.pop_front(); have = 1'b1; end
            if (sg == 0 && qu.size() > 0) begin e = qu.pop_front(); have = 1'b1; end
            if (!have) begin
                check(1'b0, "unexpected_output", yy, 64'd0);
            end else begin
                check(yy === e.y, sg ? "data_signed" : "data_unsigned", yy, e.y);
                check(dd === e.dir, "y_dir", 64'(dd), 64'(e.dir));
                if (e.hidx) check(ii === e.idx, "y_idx", 64'(ii), 64'(e.idx));
                else        check(perm_ok(e.xin, yy, ii), "y_idx_perm", 64'(ii), 64'd0);
            end
        end
        pstall[sg] = vv && !y_ready;
        py[sg]     = yy;
        pi[sg]     = ii;
        pd[sg]     = dd;
    endtask

    // Monitor: samples 2 time units after the falling edge.
    initial begin
        pstall[0] = 1'b0;
        pstall[1] = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (mode == 1) check(xr_u === (!vu || y_ready), "x_ready_ce", 64'(xr_u), 64'(!vu || y_ready));
                mon_one(yu, iu, du, vu, 0);
                mon_one(ys, is_, ds, vs, 1);
            end else begin
                pstall[0] = 1'b0;
                pstall[1] = 1'b0;
            end
        end
    end

    // Downstream ready: always high, or a 4-cycle stall at first output then random.
    initial begin
        y_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (mode == 0) begin
                y_ready = 1'b1;
                bp_seen = 1'b0;
            end else if (!bp_seen) begin
                y_ready = 1'b1;
                if (vu) begin
                    bp_seen = 1'b1;
                    bp_cnt  = 3;
                    y_ready = 1'b0;
                end
            end else if (bp_cnt > 0) begin
                y_ready = 1'b0;
                bp_cnt--;
            end else begin
                y_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(input logic [63:0] xv, input bit d,
                         input logic [63:0] eyu, input logic [23:0] eiu, input bit hu,
                         input logic [63:0] eys, input logic [23:0] eis, input bit hs);
        exp_t eu;
        exp_t es;
        bit   done;
        eu.y = hu ? eyu : sort_model(xv, d, 1'b0);
        eu.idx = eiu; eu.hidx = hu; eu.dir = d; eu.xin = xv;
        es.y = hs ? eys : sort_model(xv, d, 1'b1);
        es.idx = eis; es.hidx = hs; es.dir = d; es.xin = xv;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            x_valid = 1'b1;
            x       = xv;
            x_dir   = d;
            #1;
            if (xr_u && xr_s) begin
                qu.push_back(eu);
                qs.push_back(es);
                done = 1'b1;
            end
        end
        if (!done) check(1'b0, "issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_latency(input string nm);
        int  c;
        bit  done;
        c    = 0;
        done = 1'b0;
        for (int t = 1; t <= 20 && !done; t++) begin
            @(negedge clk);
            x_valid = 1'b0;
            #3;
            if (vu) begin
                c    = t;
                done = 1'b1;
            end
        end
        check(c == 6, nm, 64'(c), 64'd6);
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge clk);
            x_valid = 1'b0;
            #3;
            if (qu.size() == 0 && qs.size() == 0) done = 1'b1;
        end
        check(done, "drain_timeout", 64'(qu.size()), 64'd0);
    endtask

    logic [63:0] xa, ya_asc, ya_dsc, xsg, ysg_s, ysg_u, xtie;
    logic [23:0] ia_asc, ia_dsc, isg_s, isg_u, iident;

    initial begin
        xa     = pk8('{5, 3, 7, 0, 6, 2, 4, 1});
        ya_asc = pk8('{0, 1, 2, 3, 4, 5, 6, 7});
        ia_asc = pk3('{3, 7, 5, 1, 6, 0, 4, 2});
        ya_dsc = pk8('{7, 6, 5, 4, 3, 2, 1, 0});
        ia_dsc = pk3('{2, 4, 0, 6, 1, 5, 7, 3});
        xsg    = pk8('{'h80, 'h7F, 'hFF, 'h00, 'h01, 'hFE, 'h10, 'hF0});
        ysg_s  = pk8('{'h80, 'hF0, 'hFE, 'hFF, 'h00, 'h01, 'h10, 'h7F});
        isg_s  = pk3('{0, 7, 5, 2, 3, 4, 6, 1});
        ysg_u  = pk8('{'h00, 'h01, 'h10, 'h7F, 'h80, 'hF0, 'hFE, 'hFF});
        isg_u  = pk3('{3, 4, 6, 1, 0, 7, 5, 2});
        xtie   = {8{8'h2A}};
        iident = pk3('{0, 1, 2, 3, 4, 5, 6, 7});

        rst     = 1'b1;
        x_valid = 1'b0;
        x       = '0;
        x_dir   = 1'b0;
        #1 rst  = 1'b0;
        #1;
        check(!vu && !vs, "reset_y_valid", 64'(vu), 64'd0);
        check(yu === 64'd0 && iu === 24'd0 && du === 1'b0, "reset_outputs", yu, 64'd0);
        check(xr_u === 1'b1, "reset_x_ready", 64'(xr_u), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        issue(xa, 1'b1, ya_asc, ia_asc, 1'b1, ya_asc, ia_asc, 1'b1);
        wait_latency("latency_first");
        issue(xa, 1'b0, ya_dsc, ia_dsc, 1'b1, ya_dsc, ia_dsc, 1'b1);
        issue(xsg, 1'b1, ysg_u, isg_u, 1'b1, ysg_s, isg_s, 1'b1);
        issue(xtie, 1'b1, xtie, iident, 1'b1, xtie, iident, 1'b1);
        issue(xtie, 1'b0, xtie, iident, 1'b1, xtie, iident, 1'b1);
        drain(100);

        mode = 1;
        for (int i = 0; i < 10; i++)
            issue({$urandom, $urandom}, 1'(i % 2), 64'd0, 24'd0, 1'b0, 64'd0, 24'd0, 1'b0);
        drain(500);
        mode = 0;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            issue({$urandom, $urandom}, 1'(i % 2), 64'd0, 24'd0, 1'b0, 64'd0, 24'd0, 1'b0);
        @(negedge clk);
        x_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check(!vu && !vs, "midreset_y_valid", 64'(vu), 64'd0);
        check(yu === 64'd0 && iu === 24'd0 && du === 1'b0, "midreset_outputs", yu, 64'd0);
        check(xr_u === 1'b1, "midreset_x_ready", 64'(xr_u), 64'd1);
        qu.delete();
        qs.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #3;
            check(!vu && !vs, "no_stale_output", 64'(vu), 64'd0);
        end
        issue(xa, 1'b1, ya_asc, ia_asc, 1'b1, ya_asc, ia_asc, 1'b1);
        wait_latency("latency_after_reset");
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
